// File: rtl/tick_timer_pkg.sv
// Shared types and constants for the tick_timer block.
package tick_timer_pkg;

  localparam int unsigned COUNT_W_DEF = 8;
  localparam int unsigned TAP_W       = 5;
  localparam int unsigned SEL_W       = 3;

  localparam int unsigned TAP_DIV2  = 0;
  localparam int unsigned TAP_DIV4  = 1;
  localparam int unsigned TAP_DIV8  = 2;
  localparam int unsigned TAP_DIV16 = 3;
  localparam int unsigned TAP_DIV32 = 4;
  localparam int unsigned SEL_MAX   = TAP_DIV32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/tick_edge_sel.sv
// Selects one divider tap and turns its rising edges into one-cycle tick pulses.
module tick_edge_sel
  import tick_timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [TAP_W-1:0] tap,
  input  logic [SEL_W-1:0] sel,
  output logic             tick
);

  logic [SEL_W-1:0] sel_c;
  logic             tap_sel;
  logic             sel_chg;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             prev_q, prev_d;
  logic             tick_q, tick_d;

  // A select change would compare edges of two different taps, so suppress it.
  always_comb begin
    sel_c   = (sel > SEL_W'(SEL_MAX)) ? SEL_W'(SEL_MAX) : sel;
    tap_sel = tap[sel_c];
    sel_chg = (sel != sel_q);
    sel_d   = sel;
    prev_d  = tap_sel;
    tick_d  = sel_chg ? 1'b0 : (tap_sel & ~prev_q);
  end

  // prev resets high so a tap already high at reset release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q  <= '0;
      prev_q <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      prev_q <= prev_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/tick_timer.sv
// Programmable countdown timer driven by a selected divider tap.
// Optional auto-reload is compiled in with TICK_TIMER_AUTO_RELOAD_EN.
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int unsigned COUNT_W = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [TAP_W-1:0]   tap,
  input  logic [SEL_W-1:0]   sel,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_val,
  input  logic               start,
  input  logic               stop,
  output logic               tick,
  output logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic               done
);

  logic               tick_w;
  state_e             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef TICK_TIMER_AUTO_RELOAD_EN
  logic [COUNT_W-1:0] reload_q, reload_d;
`endif

  tick_edge_sel u_edge (
    .clk  (clk),
    .rst  (rst),
    .tap  (tap),
    .sel  (sel),
    .tick (tick_w)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
`ifdef TICK_TIMER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          count_d = load_val;
`ifdef TICK_TIMER_AUTO_RELOAD_EN
          reload_d = load_val;
`endif
        end else if (start && !stop && (count_q != '0)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_PAUSE;
        end else if (tick_w && (count_q != '0)) begin
          if (count_q == COUNT_W'(1)) begin
`ifdef TICK_TIMER_AUTO_RELOAD_EN
            // A zero reload value falls back to one-shot completion.
            if (reload_q != '0) begin
              count_d = reload_q;
              done_d  = 1'b1;
            end else begin
              count_d = '0;
              state_d = ST_DONE;
            end
`else
            count_d = '0;
            state_d = ST_DONE;
`endif
          end else begin
            count_d = count_q - COUNT_W'(1);
          end
        end
      end
      ST_PAUSE: begin
        if (start && !stop) state_d = ST_RUN;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (state_d == ST_DONE) done_d = 1'b1;
    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef TICK_TIMER_AUTO_RELOAD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) reload_q <= '0;
    else     reload_q <= reload_d;
  end
`endif

  assign tick  = tick_w;
  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_tick_timer.sv
// Directed self-checking bench for tick_timer with a free-running divider model.
module tb_tick_timer;
  import tick_timer_pkg::*;

  localparam int unsigned CW = COUNT_W_DEF;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    tap;
  logic [4:0]    tap_man;
  logic [4:0]    div_cnt = 5'd0;
  logic          div_en;
  logic [2:0]    sel;
  logic          load, start, stop;
  logic [CW-1:0] load_val;
  logic          tick, busy, done;
  logic [CW-1:0] count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tick_cyc = 0;
  int last_cyc = 0;

  tick_timer #(.COUNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .tap      (tap),
    .sel      (sel),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .tick     (tick),
    .count    (count),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Divider model: tap[i] is bit i of a free-running counter (/2 .. /32).
  always @(posedge clk) begin
    div_cnt <= div_cnt + 5'd1;
    cyc     <= cyc + 1;
  end

  assign tap = div_en ? div_cnt : tap_man;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 64) begin
      step(1);
      n++;
    end
    check(tag, 32'(tick), 32'd1);
    tick_cyc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; div_en = 1'b1; tap_man = 5'd0; sel = 3'd0;
    load = 1'b0; start = 1'b0; stop = 1'b0; load_val = '0;
    step(3);
    // Release reset while tap[0] is high: prev=1 must mask a false edge.
    while (div_cnt[0] !== 1'b1) step(1);
    rst = 1'b0;
    step(1);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // IDLE corner cases
    start = 1'b1; step(1); start = 1'b0;
    check("idle_start_zero", 32'(busy), 32'd0);
    load_val = 8'd6; load = 1'b1; start = 1'b1; step(1); load = 1'b0; start = 1'b0;
    check("idle_load_start_count", 32'(count), 32'd6);
    check("idle_load_start_busy", 32'(busy), 32'd0);
    start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
    check("idle_start_stop", 32'(busy), 32'd0);

    // sel=2 countdown from 3
    sel = 3'd2; load_val = 8'd3; load = 1'b1; step(1); load = 1'b0;
    check("t2_load", 32'(count), 32'd3);
    start = 1'b1; step(1); start = 1'b0;
    check("t2_busy_start", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      wait_tick("t2_tick");
      if (i > 0) check("t2_spacing", 32'(tick_cyc - last_cyc), 32'd8);
      last_cyc = tick_cyc;
      step(1);
      check("t2_count", 32'(count), 32'(2 - i));
      check("t2_done", 32'(done), 32'(i == 2));
      check("t2_busy", 32'(busy), 32'(i != 2));
    end
    step(1);
    check("t2_done_gone", 32'(done), 32'd0);
    check("t2_idle_count", 32'(count), 32'd0);
    check("t2_idle_busy", 32'(busy), 32'd0);

    // sel=0 from 5, pause after two decrements
    sel = 3'd0; load_val = 8'd5; load = 1'b1; step(1); load = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_tick("t3_tick");
      step(1);
      check("t3_count", 32'(count), 32'(4 - i));
    end
    stop = 1'b1; step(1); stop = 1'b0;
    check("t3_pause_count", 32'(count), 32'd3);
    check("t3_pause_busy", 32'(busy), 32'd1);
    step(20);
    check("t3_hold_count", 32'(count), 32'd3);
    check("t3_hold_done", 32'(done), 32'd0);
    start = 1'b1; step(1); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_tick("t3_tick2");
      step(1);
      check("t3_count2", 32'(count), 32'(2 - i));
      check("t3_done", 32'(done), 32'(i == 2));
    end
    step(1);
    check("t3_done_once", 32'(done), 32'd0);

    // start+stop together in RUN with a coincident tick
    load_val = 8'd4; load = 1'b1; step(1); load = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    wait_tick("t4_tick");
    start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
    check("t4_dropped", 32'(count), 32'd4);
    check("t4_busy", 32'(busy), 32'd1);
    step(6);
    check("t4_paused", 32'(count), 32'd4);
    start = 1'b1; step(1); start = 1'b0;
    wait_tick("t4_tick2");
    step(1);
    check("t4_resume", 32'(count), 32'd3);
    // Asynchronous reset mid-run, away from any clock edge
    #2 rst = 1'b1;
    #1;
    check("t4_arst_count", 32'(count), 32'd0);
    check("t4_arst_busy", 32'(busy), 32'd0);
    check("t4_arst_tick", 32'(tick), 32'd0);
    check("t4_arst_done", 32'(done), 32'd0);
    step(2);
    rst = 1'b0;

    // Select-change suppression and sel clamp with hand-driven taps
    div_en = 1'b0; tap_man = 5'b00000; sel = 3'd4;
    step(3);
    check("t5_idle_tick", 32'(tick), 32'd0);
    sel = 3'd0; tap_man = 5'b00001; step(1);
    check("t5_chg_tick", 32'(tick), 32'd0);
    step(1);
    check("t5_after_chg", 32'(tick), 32'd0);
    tap_man = 5'b00000; step(1);
    check("t5_low", 32'(tick), 32'd0);
    tap_man = 5'b00001; step(1);
    check("t5_rise", 32'(tick), 32'd1);
    step(1);
    check("t5_single", 32'(tick), 32'd0);
    tap_man = 5'b00000; sel = 3'd7; step(2);
    tap_man = 5'b10000; step(1);
    check("t5_clamp_tick", 32'(tick), 32'd1);
    step(1);
    check("t5_clamp_single", 32'(tick), 32'd0);
    tap_man = 5'b10001; step(1);
    check("t5_clamp_other_tap", 32'(tick), 32'd0);

`ifdef TICK_TIMER_AUTO_RELOAD_EN
    // Auto-reload: 2,1,2,1 with done every 8 cycles at sel=1
    div_en = 1'b1; sel = 3'd1; load_val = 8'd2; load = 1'b1; step(1); load = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_tick("t6_tick");
      step(1);
      check("t6_count", 32'(count), (i % 2 == 0) ? 32'd1 : 32'd2);
      check("t6_done", 32'(done), 32'(i % 2 == 1));
      check("t6_busy", 32'(busy), 32'd1);
      if (i == 1) last_cyc = cyc;
      if (i == 3) check("t6_done_spacing", 32'(cyc - last_cyc), 32'd8);
    end
    #2 rst = 1'b1;
    #1;
    check("t6_arst_count", 32'(count), 32'd0);
    check("t6_arst_busy", 32'(busy), 32'd0);
    check("t6_arst_done", 32'(done), 32'd0);
    check("t6_arst_tick", 32'(tick), 32'd0);
    step(2);
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
